// File: rtl/pipe_ctrl_n.sv
// rtl/pipe_ctrl_n.sv - pipeline stall/bubble arbiter, flush sequencer and stall watchdog (optional PIPE_CTRL_PERF_EN perf counters)
module pipe_ctrl_n #(
  parameter int NUM_STAGES = 6,
  parameter int PC_W       = 32,
  parameter int MAX_STALL  = 255,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  flush_req,
  input  logic [PC_W-1:0]       flush_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  new_pc_valid,
  output logic [PC_W-1:0]       new_pc,
  output logic                  stall_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [15:0]           perf_flushes
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

  state_t                  state_q, state_d;
  logic [PC_W-1:0]         new_pc_q, new_pc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    timeout_q, timeout_d;
  logic [NUM_STAGES-1:0]   arb_stall;
  logic [NUM_STAGES-1:0]   arb_bubble;

  // Stall everything at or below the highest requester; bubble the register just above it
  always_comb begin
    logic acc;
    acc        = 1'b0;
    arb_stall  = '0;
    arb_bubble = '0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      acc          = acc | stallreq[j];
      arb_stall[j] = acc;
    end
    for (int j = 1; j < NUM_STAGES; j++) begin
      arb_bubble[j] = arb_stall[j-1] & ~arb_stall[j];
    end
  end

  // Next-state and output decode; a pending flush discards work so stall/bubble stay low
  always_comb begin
    state_d      = state_q;
    stall        = '0;
    bubble       = '0;
    flush        = '0;
    new_pc_valid = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
        end else begin
          stall  = arb_stall;
          bubble = arb_bubble;
          if (|stallreq) state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
        end else begin
          stall  = arb_stall;
          bubble = arb_bubble;
          if (~|stallreq) state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush        = '1;
        new_pc_valid = 1'b1;
        if (flush_req)      state_d = ST_FLUSH;
        else if (|stallreq) state_d = ST_STALL;
        else                state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      stall        = '0;
      bubble       = '0;
      flush        = '0;
      new_pc_valid = 1'b0;
    end
  end

  // Redirect PC capture and watchdog next-state; FLUSH entry clears counter and flag first
  always_comb begin
    new_pc_d  = flush_req ? flush_pc : new_pc_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_d == ST_FLUSH) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (|stall) begin
      cnt_d = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + CNT_W'(1);
      if (cnt_d == MAX_CNT) timeout_d = 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  // State, redirect PC and watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      new_pc_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_pc_q  <= new_pc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign new_pc        = new_pc_q;
  assign stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  // Free-running performance counters, wrap naturally, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (|stall)               perf_stall_q <= perf_stall_q + 32'd1;
      if (state_q == ST_FLUSH)  perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// tb/tb_pipe_ctrl_n.sv - table-driven self-checking bench for pipe_ctrl_n
module tb_pipe_ctrl_n;

  logic        clk;
  logic        rst;
  logic [5:0]  stallreq;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic [5:0]  bubble;
  logic [5:0]  flush;
  logic        new_pc_valid;
  logic [31:0] new_pc;
  logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flushes;
`endif

  int checks;
  int failures;

  pipe_ctrl_n #(
    .NUM_STAGES(6),
    .PC_W(32),
    .MAX_STALL(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallreq(stallreq),
    .flush_req(flush_req),
    .flush_pc(flush_pc),
    .stall(stall),
    .bubble(bubble),
    .flush(flush),
    .new_pc_valid(new_pc_valid),
    .new_pc(new_pc),
    .stall_timeout(stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flushes(perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  sr;
    logic        fr;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic [5:0]  e_bubble;
    logic [5:0]  e_flush;
    logic        e_npv;
    logic [31:0] e_pc;
    logic        e_to;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] RUN = 2'd0, STL = 2'd1, FLS = 2'd2;

  task automatic add(input logic [5:0] sr, input logic fr, input logic [31:0] pc,
                     input logic [5:0] es, input logic [5:0] eb, input logic [5:0] ef,
                     input logic ev, input logic [31:0] epc, input logic eto, input logic [1:0] est);
    vec_t v;
    v.sr = sr; v.fr = fr; v.pc = pc;
    v.e_stall = es; v.e_bubble = eb; v.e_flush = ef;
    v.e_npv = ev; v.e_pc = epc; v.e_to = eto; v.e_state = est;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0] st;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    stallreq  = 6'b000100;
    flush_req = 1'b0;
    flush_pc  = 32'h0;

    // reset values, stall forced low while rst is high
    #2;
    chk("rst.stall",   {26'd0, stall}, 32'd0);
    chk("rst.bubble",  {26'd0, bubble}, 32'd0);
    chk("rst.flush",   {26'd0, flush}, 32'd0);
    chk("rst.npv",     {31'd0, new_pc_valid}, 32'd0);
    chk("rst.new_pc",  new_pc, 32'd0);
    chk("rst.timeout", {31'd0, stall_timeout}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    stallreq = 6'b0;
    rst = 1'b0;

    //   sr         fr    pc             stall      bubble     flush      npv   new_pc         to    state
    add(6'b000000, 1'b0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 1'b0, 32'h0,        1'b0, RUN);
    add(6'b000100, 1'b0, 32'h0,        6'b000111, 6'b001000, 6'b000000, 1'b0, 32'h0,        1'b0, RUN);
    add(6'b000100, 1'b0, 32'h0,        6'b000111, 6'b001000, 6'b000000, 1'b0, 32'h0,        1'b0, STL);
    add(6'b000100, 1'b0, 32'h0,        6'b000111, 6'b001000, 6'b000000, 1'b0, 32'h0,        1'b0, STL);
    add(6'b000000, 1'b0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 1'b0, 32'h0,        1'b0, STL);
    add(6'b000000, 1'b0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 1'b0, 32'h0,        1'b0, RUN);
    add(6'b010010, 1'b0, 32'h0,        6'b011111, 6'b100000, 6'b000000, 1'b0, 32'h0,        1'b0, RUN);
    add(6'b100000, 1'b0, 32'h0,        6'b111111, 6'b000000, 6'b000000, 1'b0, 32'h0,        1'b0, STL);
    add(6'b000100, 1'b1, 32'hBFC00380, 6'b000000, 6'b000000, 6'b000000, 1'b0, 32'h0,        1'b0, STL);
    add(6'b000100, 1'b0, 32'h0,        6'b000000, 6'b000000, 6'b111111, 1'b1, 32'hBFC00380, 1'b0, FLS);
    add(6'b000100, 1'b0, 32'h0,        6'b000111, 6'b001000, 6'b000000, 1'b0, 32'hBFC00380, 1'b0, STL);
    add(6'b000000, 1'b1, 32'h100,      6'b000000, 6'b000000, 6'b000000, 1'b0, 32'hBFC00380, 1'b0, STL);
    add(6'b000000, 1'b1, 32'h200,      6'b000000, 6'b000000, 6'b111111, 1'b1, 32'h100,      1'b0, FLS);
    add(6'b000000, 1'b0, 32'h0,        6'b000000, 6'b000000, 6'b111111, 1'b1, 32'h200,      1'b0, FLS);
    add(6'b000000, 1'b0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 1'b0, 32'h200,      1'b0, RUN);
    add(6'b000001, 1'b0, 32'h0,        6'b000001, 6'b000010, 6'b000000, 1'b0, 32'h200,      1'b0, RUN);
    add(6'b000001, 1'b0, 32'h0,        6'b000001, 6'b000010, 6'b000000, 1'b0, 32'h200,      1'b0, STL);
    add(6'b000001, 1'b0, 32'h0,        6'b000001, 6'b000010, 6'b000000, 1'b0, 32'h200,      1'b0, STL);
    add(6'b000001, 1'b0, 32'h0,        6'b000001, 6'b000010, 6'b000000, 1'b0, 32'h200,      1'b0, STL);
    add(6'b000001, 1'b0, 32'h0,        6'b000001, 6'b000010, 6'b000000, 1'b0, 32'h200,      1'b1, STL);
    add(6'b000001, 1'b0, 32'h0,        6'b000001, 6'b000010, 6'b000000, 1'b0, 32'h200,      1'b1, STL);
    add(6'b000000, 1'b0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 1'b0, 32'h200,      1'b1, STL);
    add(6'b000000, 1'b0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 1'b0, 32'h200,      1'b1, RUN);
    add(6'b000000, 1'b1, 32'h300,      6'b000000, 6'b000000, 6'b000000, 1'b0, 32'h200,      1'b1, RUN);
    add(6'b000000, 1'b0, 32'h0,        6'b000000, 6'b000000, 6'b111111, 1'b1, 32'h300,      1'b0, FLS);
    add(6'b000000, 1'b0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 1'b0, 32'h300,      1'b0, RUN);

    for (int i = 0; i < vecs.size(); i++) begin
      stallreq  = vecs[i].sr;
      flush_req = vecs[i].fr;
      flush_pc  = vecs[i].pc;
      @(negedge clk);
      st = dut.state_q;
      chk($sformatf("v%0d.stall", i),   {26'd0, stall},  {26'd0, vecs[i].e_stall});
      chk($sformatf("v%0d.bubble", i),  {26'd0, bubble}, {26'd0, vecs[i].e_bubble});
      chk($sformatf("v%0d.flush", i),   {26'd0, flush},  {26'd0, vecs[i].e_flush});
      chk($sformatf("v%0d.npv", i),     {31'd0, new_pc_valid}, {31'd0, vecs[i].e_npv});
      chk($sformatf("v%0d.new_pc", i),  new_pc, vecs[i].e_pc);
      chk($sformatf("v%0d.timeout", i), {31'd0, stall_timeout}, {31'd0, vecs[i].e_to});
      chk($sformatf("v%0d.state", i),   {30'd0, st}, {30'd0, vecs[i].e_state});
      @(posedge clk); #1;
    end

    // asynchronous reset in the middle of a FLUSH cycle
    stallreq  = 6'b000100;
    flush_req = 1'b1;
    flush_pc  = 32'h400;
    @(posedge clk); #1;
    flush_req = 1'b0;
    chk("pre_rst.flush", {26'd0, flush}, 32'h3f);
    #2;
    rst = 1'b1;
    #1;
    st = dut.state_q;
    chk("async_rst.flush",   {26'd0, flush}, 32'd0);
    chk("async_rst.npv",     {31'd0, new_pc_valid}, 32'd0);
    chk("async_rst.stall",   {26'd0, stall}, 32'd0);
    chk("async_rst.bubble",  {26'd0, bubble}, 32'd0);
    chk("async_rst.timeout", {31'd0, stall_timeout}, 32'd0);
    chk("async_rst.new_pc",  new_pc, 32'd0);
    chk("async_rst.state",   {30'd0, st}, 32'd0);
    stallreq = 6'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d.flush", c), {26'd0, flush}, 32'd0);
      chk($sformatf("post_rst%0d.npv", c),   {31'd0, new_pc_valid}, 32'd0);
      chk($sformatf("post_rst%0d.stall", c), {26'd0, stall}, 32'd0);
      @(posedge clk); #1;
    end
`ifdef PIPE_CTRL_PERF_EN
    chk("post_rst.perf_stall", perf_stall_cycles, 32'd0);
    chk("post_rst.perf_flush", {16'd0, perf_flushes}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
